// File: rtl/beam_rx_combiner.sv
// beam_rx_combiner
//   Four 1-bit receive channels, each delayed by a per-channel programmable
//   number of sample strobes (0..15). The delayed taps are counted per strobe
//   and integrated over WINDOW strobes. A fill phase of 15 strobes primes the
//   delay lines before any integration starts.
//
//   Optional feature: define BEAM_RX_DETECT_EN to add a registered detect
//   flag (result >= DETECT_THRESH) on uio_out[6]; otherwise it is tied to 0.
//
// Ports
//   clk      sole clock, rising edge
//   rst      synchronous active-high reset
//   ena      block enable; low freezes all state and masks pulse outputs
//   ui_in    [3:0] ch0..ch3 samples, [4] cfg_valid, [6:5] cfg_ch, [7] sample_valid
//   uio_in   [3:0] cfg_delay, [7:4] unused
//   uo_out   [6:0] last window result, [7] result_valid pulse
//   uio_out  [4] cfg_ack pulse, [5] busy, [6] detect, others 0
//   uio_oe   constant 8'hF0
module beam_rx_combiner #(
  parameter int unsigned WINDOW        = 16,
  parameter int unsigned DETECT_THRESH = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [14:0] sr_q  [4];
  logic [14:0] sr_d  [4];
  logic [3:0]  dly_q [4];
  logic [3:0]  dly_d [4];
  logic [3:0]  fill_q, fill_d;
  logic [4:0]  win_q, win_d;
  logic [6:0]  acc_q, acc_d;
  logic [6:0]  res_q, res_d;
  logic        valid_q, valid_d;
  logic        ack_q, ack_d;
  logic        det_q, det_d;

  logic        strobe;
  logic        cfg;
  logic [1:0]  cfg_ch;
  logic [3:0]  tap;
  logic [2:0]  sum;
  logic [6:0]  acc_sum;
  logic        unused_ok;

  assign strobe  = ena & ui_in[7];
  assign cfg     = ena & ui_in[4];
  assign cfg_ch  = ui_in[6:5];
  assign acc_sum = acc_q + {4'd0, sum};

  // Delay d>=1 reads the pre-shift register entry d-1, i.e. the sample from
  // d strobes ago; delay 0 bypasses the line with the live input.
  always_comb begin
    tap = '0;
    for (int unsigned ch = 0; ch < 4; ch++) begin
      if (dly_q[ch] == 4'd0) tap[ch] = ui_in[ch];
      else                   tap[ch] = sr_q[ch][dly_q[ch] - 4'd1];
    end
    sum = {2'd0, tap[0]} + {2'd0, tap[1]} + {2'd0, tap[2]} + {2'd0, tap[3]};
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    win_d   = win_q;
    acc_d   = acc_q;
    res_d   = res_q;
    det_d   = det_q;
    valid_d = 1'b0;
    ack_d   = 1'b0;
    for (int unsigned ch = 0; ch < 4; ch++) begin
      sr_d[ch]  = sr_q[ch];
      dly_d[ch] = dly_q[ch];
    end

    if (ena) begin
      if (strobe) begin
        for (int unsigned ch = 0; ch < 4; ch++) sr_d[ch] = {sr_q[ch][13:0], ui_in[ch]};
      end

      unique case (state_q)
        S_FILL: begin
          if (strobe) begin
            if (fill_q == 4'd14) begin
              fill_d  = '0;
              state_d = S_RUN;
            end else begin
              fill_d = fill_q + 4'd1;
            end
          end
        end
        S_RUN: begin
          if (strobe) begin
            if (win_q == 5'(WINDOW - 1)) begin
              res_d   = acc_sum;
              valid_d = 1'b1;
              acc_d   = '0;
              win_d   = '0;
`ifdef BEAM_RX_DETECT_EN
              det_d   = (acc_sum >= 7'(DETECT_THRESH));
`endif
            end else begin
              acc_d = acc_sum;
              win_d = win_q + 5'd1;
            end
          end
        end
        default: state_d = S_FILL;
      endcase

      // A config write overrides any same-cycle strobe outcome in RUN: the
      // partial window (including a would-be completion) is thrown away.
      if (cfg) begin
        dly_d[cfg_ch] = uio_in[3:0];
        ack_d         = 1'b1;
        if (state_q == S_RUN) begin
          acc_d   = '0;
          win_d   = '0;
          res_d   = res_q;
          det_d   = det_q;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      fill_q  <= '0;
      win_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      det_q   <= 1'b0;
      for (int unsigned ch = 0; ch < 4; ch++) begin
        sr_q[ch]  <= '0;
        dly_q[ch] <= '0;
      end
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      det_q   <= det_d;
      for (int unsigned ch = 0; ch < 4; ch++) begin
        sr_q[ch]  <= sr_d[ch];
        dly_q[ch] <= dly_d[ch];
      end
    end
  end

  logic busy;
  logic detect;
  assign busy = (state_q == S_RUN) && (win_q != 5'd0);

`ifdef BEAM_RX_DETECT_EN
  assign detect    = det_q;
  assign unused_ok = ^uio_in[7:4];
`else
  assign detect    = 1'b0;
  assign unused_ok = ^{uio_in[7:4], det_q, 7'(DETECT_THRESH)};
`endif

  assign uo_out  = {valid_q & ena, res_q};
  assign uio_out = {1'b0, detect, busy, ack_q & ena, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_beam_rx_combiner.sv
module tb_beam_rx_combiner;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [6:0] res;
    logic       det;
  } exp_t;
  exp_t exp_q[$];

  beam_rx_combiner #(.WINDOW(16), .DETECT_THRESH(48)) dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int r);
    exp_t e;
    e.res = 7'(r);
`ifdef BEAM_RX_DETECT_EN
    e.det = (r >= 48);
`else
    e.det = 1'b0;
`endif
    return e;
  endfunction

  // Scoreboard monitor: every result_valid pulse must match the oldest
  // expected window result.
  always @(negedge clk) begin
    if (!rst && uo_out[7]) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got result %0d, expected no pulse", uo_out[6:0]);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", int'(uo_out[6:0]), int'(e.res));
        chk("detect", int'(uio_out[6]), int'(e.det));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] s);
    ui_in = {1'b1, 3'b000, s};
    tick();
    ui_in = '0;
  endtask

  task automatic strobes(input int n, input logic [3:0] s);
    for (int i = 0; i < n; i++) strobe(s);
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [3:0] d, input bit with_strobe,
                           input logic [3:0] s);
    ui_in  = {with_strobe, ch, 1'b1, s};
    uio_in = {4'h0, d};
    tick();
    ui_in  = '0;
    uio_in = '0;
    chk("cfg_ack", int'(uio_out[4]), 1);
  endtask

  initial begin
    rst    = 1'b1;
    ena    = 1'b1;
    ui_in  = '0;
    uio_in = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_uo_out", int'(uo_out), 0);
    chk("reset_uio_out", int'(uio_out), 0);
    chk("uio_oe", int'(uio_oe), 8'hF0);

    // All ones, delays 0: 15 fill strobes then a 16-strobe window of 4s.
    strobes(15, 4'hF);
    chk("busy_after_fill", int'(uio_out[5]), 0);
    strobes(5, 4'hF);
    chk("busy_mid_window", int'(uio_out[5]), 1);
    strobes(10, 4'hF);
    exp_q.push_back(mk(64));
    strobe(4'hF);
    chk("busy_after_window", int'(uio_out[5]), 0);

    // Only ch2 high.
    strobes(15, 4'b0100);
    exp_q.push_back(mk(16));
    strobe(4'b0100);

    // Flush delay lines with zeros (result 0).
    strobes(15, 4'h0);
    exp_q.push_back(mk(0));
    strobe(4'h0);

    // Delays 0,3,7,15; staggered single pulses coincide on the last strobe.
    cfg_write(2'd0, 4'd0,  1'b0, 4'h0);
    cfg_write(2'd1, 4'd3,  1'b0, 4'h0);
    cfg_write(2'd2, 4'd7,  1'b0, 4'h0);
    cfg_write(2'd3, 4'd15, 1'b0, 4'h0);
    for (int j = 0; j < 16; j++) begin
      logic [3:0] s;
      s = 4'h0;
      if (j == 0)  s = 4'b1000;
      if (j == 8)  s = 4'b0100;
      if (j == 12) s = 4'b0010;
      if (j == 15) begin
        s = 4'b0001;
        exp_q.push_back(mk(4));
      end
      strobe(s);
    end

    // Config write coincident with window strobe 8 discards the window.
    strobes(8, 4'hF);
    cfg_write(2'd1, 4'd3, 1'b1, 4'hF);
    chk("hold_after_cfg", int'(uo_out[6:0]), 4);
    chk("busy_after_cfg", int'(uio_out[5]), 0);
    strobes(15, 4'hF);
    exp_q.push_back(mk(58));
    strobe(4'hF);

    // Freeze for 10 cycles with strobes and config attempted.
    strobes(5, 4'hF);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ui_in  = {i[0], 2'd0, 1'b1, 4'h0};
      uio_in = 8'h0F;
      tick();
      chk("frozen_ack_low", int'(uio_out[4]), 0);
    end
    ui_in  = '0;
    uio_in = '0;
    ena    = 1'b1;
    chk("frozen_busy_held", int'(uio_out[5]), 1);
    chk("frozen_result_held", int'(uo_out[6:0]), 58);
    strobes(10, 4'hF);
    exp_q.push_back(mk(64));
    strobe(4'hF);

    // Reset at window strobe 10.
    strobes(10, 4'hF);
    rst   = 1'b1;
    ui_in = 8'h8F;
    tick();
    rst   = 1'b0;
    ui_in = '0;
    chk("midreset_uo_out", int'(uo_out), 0);
    chk("midreset_uio_out", int'(uio_out), 0);

    // Fill again, with a config write partway through that must not restart it.
    strobes(5, 4'b0011);
    cfg_write(2'd0, 4'd0, 1'b0, 4'h0);
    strobes(10, 4'b0011);
    strobes(15, 4'b0011);
    exp_q.push_back(mk(32));
    strobe(4'b0011);

    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
